cpu7_exu_wbarb: RTL and testbench

//  Arbitrates the single integer register-file write port (waddr1/wen1/wdata1) between ALU writeback (w stage)
//  and LSU load return (m stage). Load return always wins: the memory side cannot be back-pressured.
//  A displaced ALU result is parked in a small in-order FIFO and written later.

---
 rtl/cpu7_exu_wbarb.sv | 160 ++++++++++++++++
 tb/tb_cpu7_exu_wbarb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_exu_wbarb.sv
// Write-port arbiter for the integer register file: load returns win, displaced ALU
// results queue in order, and a load scoreboard drives the d-stage stall.
module cpu7_exu_wbarb #(
    parameter int GRLEN    = 32,
    parameter int DEPTH    = 4,
    parameter int INFLIGHT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             alu_wen_w,
    input  logic [4:0]       alu_rd_w,
    input  logic [GRLEN-1:0] alu_data_w,
    input  logic [GRLEN-1:0] alu_pc_w,
    input  logic             lsu_issue_e,
    input  logic [4:0]       lsu_issue_rd_e,
    input  logic             lsu_ret_valid_m,
    input  logic [4:0]       lsu_ret_rd_m,
    input  logic [GRLEN-1:0] lsu_ret_data_m,
    input  logic [GRLEN-1:0] lsu_ret_pc_m,
    input  logic [4:0]       dec_rs1_d,
    input  logic [4:0]       dec_rs2_d,
    input  logic             dec_rs1_en_d,
    input  logic             dec_rs2_en_d,
    input  logic [4:0]       dec_rd_d,
    input  logic             dec_wen_d,
    input  logic             dec_valid_d,
    output logic             ecl_irf_wen_w,
    output logic [4:0]       ecl_irf_rd_w,
    output logic [GRLEN-1:0] ecl_irf_rd_data_w,
    output logic [GRLEN-1:0] wb_pc_w,
    output logic             exu_ifu_stall_req,
    output logic             wbarb_ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [4:0]       fifo_rd   [DEPTH];
    logic [GRLEN-1:0] fifo_data [DEPTH];
    logic [GRLEN-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [31:0]      sb;
    logic [31:0]      sb_set;
    logic [31:0]      sb_clr;
    logic [31:0]      sb_next;
    logic [DEPTH-1:0] fifo_vld;
    logic             ovf_q;

    logic fifo_nempty;
    logic fifo_full;
    logic push_req;
    logic push;
    logic pop;
    logic drop;

    assign fifo_nempty = (count != '0);
    assign fifo_full   = (count == (PW+1)'(DEPTH));
    assign push_req    = alu_wen_w & (lsu_ret_valid_m | fifo_nempty);
    assign pop         = ~lsu_ret_valid_m & fifo_nempty;
    // A full FIFO that drains its head this cycle still has room for the new result.
    assign push        = push_req & (~fifo_full | pop);
    assign drop        = push_req & fifo_full & ~pop;

    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [GRLEN-1:0] sel_data;
    logic [GRLEN-1:0] sel_pc;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        sel_pc    = '0;
        if (lsu_ret_valid_m) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_ret_rd_m;
            sel_data  = lsu_ret_data_m;
            sel_pc    = lsu_ret_pc_m;
        end else if (fifo_nempty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[head];
            sel_data  = fifo_data[head];
            sel_pc    = fifo_pc[head];
        end else if (alu_wen_w) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd_w;
            sel_data  = alu_data_w;
            sel_pc    = alu_pc_w;
        end
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign ecl_irf_wen_w     = resetn & sel_valid & (sel_rd != 5'd0);
    assign ecl_irf_rd_w      = resetn ? sel_rd : 5'd0;
    assign ecl_irf_rd_data_w = resetn ? sel_data : '0;
    assign wb_pc_w           = resetn ? sel_pc : '0;
    assign wbarb_ovf         = ovf_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_vld[i] = ({1'b0, PW'(i) - head} < count);
        end
    end

    logic hit_rs1;
    logic hit_rs2;

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && fifo_rd[i] == dec_rs1_d) hit_rs1 = 1'b1;
            if (fifo_vld[i] && fifo_rd[i] == dec_rs2_d) hit_rs2 = 1'b1;
        end
    end

    logic raw;
    logic waw;
    logic cnt_haz;

    assign raw = (dec_rs1_en_d & (dec_rs1_d != 5'd0) & (sb[dec_rs1_d] | hit_rs1))
               | (dec_rs2_en_d & (dec_rs2_d != 5'd0) & (sb[dec_rs2_d] | hit_rs2));
    assign waw = dec_wen_d & (dec_rd_d != 5'd0) & sb[dec_rd_d];
    assign cnt_haz = (int'(count) + INFLIGHT >= DEPTH);
    assign exu_ifu_stall_req = resetn & ((dec_valid_d & (raw | waw)) | cnt_haz);

    // Set is applied after clear so a new load to the same rd keeps its bit.
    always_comb begin
        sb_set  = (lsu_issue_e && lsu_issue_rd_e != 5'd0) ? (32'd1 << lsu_issue_rd_e) : 32'd0;
        sb_clr  = lsu_ret_valid_m ? (32'd1 << lsu_ret_rd_m) : 32'd0;
        sb_next = ((sb & ~sb_clr) | sb_set) & ~32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            sb    <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (pop)  head <= head + PW'(1);
            if (push) tail <= tail + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (!push && pop) count <= count - (PW+1)'(1);
            sb    <= sb_next;
            ovf_q <= ovf_q | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= alu_rd_w;
            fifo_data[tail] <= alu_data_w;
            fifo_pc[tail]   <= alu_pc_w;
        end
    end

endmodule

// File: tb/tb_cpu7_exu_wbarb.sv
// Directed bench for cpu7_exu_wbarb: a queue/bit-array model checked every negedge,
// plus literal expectations at each scenario step.
module tb_cpu7_exu_wbarb;

    localparam int DEPTH    = 4;
    localparam int INFLIGHT = 2;

    logic        clk;
    logic        resetn;
    logic        alu_wen_w;
    logic [4:0]  alu_rd_w;
    logic [31:0] alu_data_w;
    logic [31:0] alu_pc_w;
    logic        lsu_issue_e;
    logic [4:0]  lsu_issue_rd_e;
    logic        lsu_ret_valid_m;
    logic [4:0]  lsu_ret_rd_m;
    logic [31:0] lsu_ret_data_m;
    logic [31:0] lsu_ret_pc_m;
    logic [4:0]  dec_rs1_d;
    logic [4:0]  dec_rs2_d;
    logic        dec_rs1_en_d;
    logic        dec_rs2_en_d;
    logic [4:0]  dec_rd_d;
    logic        dec_wen_d;
    logic        dec_valid_d;
    logic        ecl_irf_wen_w;
    logic [4:0]  ecl_irf_rd_w;
    logic [31:0] ecl_irf_rd_data_w;
    logic [31:0] wb_pc_w;
    logic        exu_ifu_stall_req;
    logic        wbarb_ovf;

    cpu7_exu_wbarb #(.GRLEN(32), .DEPTH(DEPTH), .INFLIGHT(INFLIGHT)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .alu_wen_w         (alu_wen_w),
        .alu_rd_w          (alu_rd_w),
        .alu_data_w        (alu_data_w),
        .alu_pc_w          (alu_pc_w),
        .lsu_issue_e       (lsu_issue_e),
        .lsu_issue_rd_e    (lsu_issue_rd_e),
        .lsu_ret_valid_m   (lsu_ret_valid_m),
        .lsu_ret_rd_m      (lsu_ret_rd_m),
        .lsu_ret_data_m    (lsu_ret_data_m),
        .lsu_ret_pc_m      (lsu_ret_pc_m),
        .dec_rs1_d         (dec_rs1_d),
        .dec_rs2_d         (dec_rs2_d),
        .dec_rs1_en_d      (dec_rs1_en_d),
        .dec_rs2_en_d      (dec_rs2_en_d),
        .dec_rd_d          (dec_rd_d),
        .dec_wen_d         (dec_wen_d),
        .dec_valid_d       (dec_valid_d),
        .ecl_irf_wen_w     (ecl_irf_wen_w),
        .ecl_irf_rd_w      (ecl_irf_rd_w),
        .ecl_irf_rd_data_w (ecl_irf_rd_data_w),
        .wb_pc_w           (wb_pc_w),
        .exu_ifu_stall_req (exu_ifu_stall_req),
        .wbarb_ovf         (wbarb_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    bit          m_sb[32];
    bit          m_ovf;
    bit          e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    bit          e_stall;
    bit          m_push;
    bit          m_pop;

    function automatic bit busy(input logic [4:0] r);
        bit hit = 0;
        if (r == 0) return 0;
        if (m_sb[r]) hit = 1;
        foreach (m_q[i]) if (m_q[i].rd == r) hit = 1;
        return hit;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_wen", ecl_irf_wen_w, 0);
            chk("rst_stall", exu_ifu_stall_req, 0);
            chk("rst_ovf", wbarb_ovf, 0);
            m_q.delete();
            foreach (m_sb[i]) m_sb[i] = 0;
            m_ovf = 0;
        end else begin
            e_valid = 0; e_rd = 0; e_data = 0; e_pc = 0;
            if (lsu_ret_valid_m) begin
                e_valid = 1; e_rd = lsu_ret_rd_m; e_data = lsu_ret_data_m; e_pc = lsu_ret_pc_m;
            end else if (m_q.size() > 0) begin
                e_valid = 1; e_rd = m_q[0].rd; e_data = m_q[0].data; e_pc = m_q[0].pc;
            end else if (alu_wen_w) begin
                e_valid = 1; e_rd = alu_rd_w; e_data = alu_data_w; e_pc = alu_pc_w;
            end
            e_valid = e_valid && (e_rd != 0);
            e_stall = (m_q.size() + INFLIGHT >= DEPTH) ||
                      (dec_valid_d && ((dec_rs1_en_d && busy(dec_rs1_d)) ||
                                       (dec_rs2_en_d && busy(dec_rs2_d)) ||
                                       (dec_wen_d && dec_rd_d != 0 && m_sb[dec_rd_d])));
            chk("m_wen", ecl_irf_wen_w, e_valid);
            if (e_valid) begin
                chk("m_rd", ecl_irf_rd_w, e_rd);
                chk("m_data", ecl_irf_rd_data_w, e_data);
                chk("m_pc", wb_pc_w, e_pc);
            end
            chk("m_stall", exu_ifu_stall_req, e_stall);
            chk("m_ovf", wbarb_ovf, m_ovf);
            // next state
            m_pop  = !lsu_ret_valid_m && m_q.size() > 0;
            m_push = alu_wen_w && (lsu_ret_valid_m || m_q.size() > 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() >= DEPTH) m_ovf = 1;
                else m_q.push_back('{alu_rd_w, alu_data_w, alu_pc_w});
            end
            if (lsu_ret_valid_m) m_sb[lsu_ret_rd_m] = 0;
            if (lsu_issue_e && lsu_issue_rd_e != 0) m_sb[lsu_issue_rd_e] = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        alu_wen_w = 0; alu_rd_w = 0; alu_data_w = 0; alu_pc_w = 0;
        lsu_issue_e = 0; lsu_issue_rd_e = 0;
        lsu_ret_valid_m = 0; lsu_ret_rd_m = 0; lsu_ret_data_m = 0; lsu_ret_pc_m = 0;
        dec_rs1_d = 0; dec_rs2_d = 0; dec_rs1_en_d = 0; dec_rs2_en_d = 0;
        dec_rd_d = 0; dec_wen_d = 0; dec_valid_d = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        alu_wen_w = 1; alu_rd_w = r; alu_data_w = d; alu_pc_w = 32'h1000 + d;
    endtask

    task automatic ret(input logic [4:0] r, input logic [31:0] d);
        lsu_ret_valid_m = 1; lsu_ret_rd_m = r; lsu_ret_data_m = d; lsu_ret_pc_m = 32'h2000 + d;
    endtask

    task automatic issue(input logic [4:0] r);
        lsu_issue_e = 1; lsu_issue_rd_e = r;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic rs1_en, input logic [4:0] rs2,
                       input logic rs2_en, input logic [4:0] rd, input logic wen);
        dec_valid_d = 1; dec_rs1_d = rs1; dec_rs1_en_d = rs1_en;
        dec_rs2_d = rs2; dec_rs2_en_d = rs2_en; dec_rd_d = rd; dec_wen_d = wen;
    endtask

    initial begin
        resetn = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wen", ecl_irf_wen_w, 0);
        chk("reset_stall", exu_ifu_stall_req, 0);
        chk("reset_ovf", wbarb_ovf, 0);
        resetn = 1;

        // ALU-only, zero latency
        nxt(); alu(5, 32'h11); #1;
        chk("alu_wen", ecl_irf_wen_w, 1);
        chk("alu_rd", ecl_irf_rd_w, 5);
        chk("alu_data", ecl_irf_rd_data_w, 32'h11);
        chk("alu_pc", wb_pc_w, 32'h1011);
        nxt(); alu(6, 32'h22); #1;
        chk("alu2_rd", ecl_irf_rd_w, 6);

        // collision: load wins, ALU result written next cycle
        nxt(); ret(3, 32'hAA); alu(4, 32'hBB); #1;
        chk("col0_rd", ecl_irf_rd_w, 3);
        chk("col0_data", ecl_irf_rd_data_w, 32'hAA);
        nxt(); #1;
        chk("col1_rd", ecl_irf_rd_w, 4);
        chk("col1_data", ecl_irf_rd_data_w, 32'hBB);
        nxt(); #1;
        chk("col2_wen", ecl_irf_wen_w, 0);

        // ordering with stall on FIFO pressure
        for (int k = 0; k < 3; k++) begin
            nxt(); ret(5'(10 + k), 32'hC0 + k); alu(5'(6 + k), 32'h60 + k); #1;
            chk("ord_ld_rd", ecl_irf_rd_w, 10 + k);
            chk("ord_ld_stall", exu_ifu_stall_req, (k == 2));
        end
        for (int j = 0; j < 3; j++) begin
            nxt(); #1;
            chk("ord_alu_rd", ecl_irf_rd_w, 6 + j);
            chk("ord_alu_data", ecl_irf_rd_data_w, 32'h60 + j);
            chk("ord_alu_stall", exu_ifu_stall_req, (j < 2));
        end
        nxt(); #1;
        chk("ord_done_wen", ecl_irf_wen_w, 0);
        chk("ord_ovf", wbarb_ovf, 0);

        // RAW on pending load
        nxt(); issue(9); #1;
        chk("raw_issue_stall", exu_ifu_stall_req, 0);
        nxt(); dec(9, 1, 0, 0, 0, 0); #1;
        chk("raw_stall", exu_ifu_stall_req, 1);
        nxt(); dec(9, 1, 0, 0, 0, 0); ret(9, 32'h99); #1;
        chk("raw_ret_stall", exu_ifu_stall_req, 1);
        chk("raw_ret_rd", ecl_irf_rd_w, 9);
        nxt(); dec(9, 1, 0, 0, 0, 0); #1;
        chk("raw_clear", exu_ifu_stall_req, 0);

        // disabled source does not stall
        nxt(); issue(15);
        nxt(); dec(0, 0, 15, 0, 0, 0); ret(15, 32'h15); #1;
        chk("rs2_dis_stall", exu_ifu_stall_req, 0);

        // r0 never hazards and never writes
        nxt(); issue(0);
        nxt(); dec(0, 1, 0, 1, 0, 1); #1;
        chk("r0_stall", exu_ifu_stall_req, 0);
        nxt(); ret(0, 32'h55); #1;
        chk("r0_wen", ecl_irf_wen_w, 0);

        // WAW on pending load
        nxt(); issue(2);
        nxt(); dec(0, 0, 0, 0, 2, 1); #1;
        chk("waw_stall", exu_ifu_stall_req, 1);
        nxt(); dec(0, 0, 0, 0, 2, 1); ret(2, 32'h22); #1;
        chk("waw_ret_stall", exu_ifu_stall_req, 1);
        nxt(); dec(0, 0, 0, 0, 2, 1); #1;
        chk("waw_clear", exu_ifu_stall_req, 0);

        // RAW against a parked FIFO entry
        nxt(); ret(13, 32'hD); alu(14, 32'hE);
        nxt(); dec(0, 0, 14, 1, 0, 0); #1;
        chk("fifo_raw_stall", exu_ifu_stall_req, 1);
        chk("fifo_raw_rd", ecl_irf_rd_w, 14);
        nxt(); dec(0, 0, 14, 1, 0, 0); #1;
        chk("fifo_raw_clear", exu_ifu_stall_req, 0);

        // set beats clear on the same register
        nxt(); issue(20);
        nxt(); issue(20); ret(20, 32'h1);
        nxt(); dec(20, 1, 0, 0, 0, 0); #1;
        chk("setwins_stall", exu_ifu_stall_req, 1);
        nxt(); ret(20, 32'h2);
        nxt(); dec(20, 1, 0, 0, 0, 0); #1;
        chk("setwins_clear", exu_ifu_stall_req, 0);

        // overflow: fifth displaced result with the FIFO full is dropped
        for (int k = 0; k < 5; k++) begin
            nxt(); ret(21, 32'h300 + k); alu(5'(22 + k), 32'h400 + k);
        end
        nxt(); #1;
        chk("ovf_set", wbarb_ovf, 1);
        chk("ovf_head_rd", ecl_irf_rd_w, 22);
        repeat (5) nxt();
        #1;
        chk("ovf_sticky", wbarb_ovf, 1);

        // async reset mid-operation
        nxt(); issue(5);
        for (int k = 0; k < 3; k++) begin
            nxt(); ret(23, 32'h500 + k); alu(5'(24 + k), 32'h600 + k);
        end
        nxt(); #1;
        chk("pre_rst_stall", exu_ifu_stall_req, 1);
        chk("pre_rst_wen", ecl_irf_wen_w, 1);
        resetn = 0;
        #1;
        chk("mid_rst_wen", ecl_irf_wen_w, 0);
        chk("mid_rst_stall", exu_ifu_stall_req, 0);
        chk("mid_rst_ovf", wbarb_ovf, 0);
        nxt();
        nxt(); resetn = 1; dec(5, 1, 0, 0, 0, 0); alu(7, 32'h77); #1;
        chk("post_rst_stall", exu_ifu_stall_req, 0);
        chk("post_rst_rd", ecl_irf_rd_w, 7);
        chk("post_rst_data", ecl_irf_rd_data_w, 32'h77);

        nxt();
        nxt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
